// File: rtl/partition_engine.sv
// Partition table engine: creates, splits and merges region masks, classifies the
// table as structured or not, and keeps saturating discovery/execution mu ledgers.
module partition_engine #(
  parameter int MAX_MODULES  = 16,
  parameter int REGION_WIDTH = 128,
  parameter int MU_WIDTH     = 32,
  parameter int AVG_THRESH   = 8,
  parameter int MAX_THRESH   = 16,
  parameter int MERGE_COST   = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                op_valid,
  output logic                                op_ready,
  input  logic [7:0]                          op,
  input  logic [REGION_WIDTH-1:0]             arg_region,
  input  logic [7:0]                          arg_m1,
  input  logic [7:0]                          arg_m2,
  output logic                                done,
  output logic                                err,
  output logic [2:0]                          err_code,
  output logic [7:0]                          result_id,
  output logic [7:0]                          num_modules,
  output logic                                is_structured,
  output logic [MU_WIDTH-1:0]                 mu_discovery,
  output logic [MU_WIDTH-1:0]                 mu_execution,
  output logic [MU_WIDTH-1:0]                 mu_cost,
  output logic                                mu_sat,
  output logic [MAX_MODULES*REGION_WIDTH-1:0] partitions
);
  localparam int IW = (MAX_MODULES > 1) ? $clog2(MAX_MODULES) : 1;

  localparam logic [7:0] OP_PNEW   = 8'h00;
  localparam logic [7:0] OP_PSPLIT = 8'h01;
  localparam logic [7:0] OP_PMERGE = 8'h02;
  localparam logic [7:0] OP_MDLACC = 8'h05;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SCAN, S_DONE} state_t;

  state_t                  state_reg;
  logic [7:0]              op_reg, m1_reg, m2_reg;
  logic [REGION_WIDTH-1:0] region_reg;
  logic [REGION_WIDTH-1:0] table_reg [MAX_MODULES];
  logic [7:0]              count_reg, result_reg, scan_idx_reg;
  logic                    struct_reg, sat_reg, done_reg, err_reg;
  logic [2:0]              code_reg;
  logic [MU_WIDTH-1:0]     disc_reg, exec_reg;
  logic [31:0]             sum_reg, max_reg;

  function automatic logic [31:0] popcount(input logic [REGION_WIDTH-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int k = 0; k < REGION_WIDTH; k++) c = c + {31'b0, v[k]};
    return c;
  endfunction

  // Top bit of the result flags saturation.
  function automatic logic [MU_WIDTH:0] sat_add(input logic [MU_WIDTH-1:0] a, input logic [31:0] b);
    logic [MU_WIDTH+32:0] s;
    s = {33'b0, a} + {{(MU_WIDTH+1){1'b0}}, b};
    if (s > {33'b0, {MU_WIDTH{1'b1}}}) return {1'b1, {MU_WIDTH{1'b1}}};
    return {1'b0, s[MU_WIDTH-1:0]};
  endfunction

  logic [MAX_MODULES-1:0] hit_vec;
  logic                   hit_any;
  logic [7:0]             hit_idx;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_MODULES; gi++) begin : g_slot
      assign hit_vec[gi] = (8'(gi) < count_reg) && (table_reg[gi] == region_reg);
      assign partitions[gi*REGION_WIDTH +: REGION_WIDTH] = table_reg[gi];
    end
  endgenerate

  logic                    table_full, m1_ok, m2_ok, scan_last, structured_next;
  logic [7:0]              last_idx;
  logic [REGION_WIDTH-1:0] merge_val, tail_val;
  logic [31:0]             exec_amt, scan_pc, scan_sum_next, scan_max_next;
  logic [MU_WIDTH:0]       disc_add_next, exec_add_next, cost_sum;

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = MAX_MODULES - 1; k >= 0; k--) begin
      if (hit_vec[k]) begin
        hit_any = 1'b1;
        hit_idx = 8'(k);
      end
    end
    table_full = (count_reg == 8'(MAX_MODULES));
    m1_ok      = (m1_reg < count_reg);
    m2_ok      = (m2_reg < count_reg);
    last_idx   = count_reg - 8'd1;
    merge_val  = table_reg[m1_reg[IW-1:0]] | table_reg[m2_reg[IW-1:0]];
    // When m1 is itself the tail, the merged value is what gets relocated into m2.
    tail_val   = (m1_reg == last_idx) ? merge_val : table_reg[last_idx[IW-1:0]];
    case (op_reg)
      OP_PSPLIT: exec_amt = 32'(REGION_WIDTH);
      OP_PMERGE: exec_amt = 32'(MERGE_COST);
      default:   exec_amt = {24'b0, count_reg} << 3;
    endcase
    disc_add_next   = sat_add(disc_reg, popcount(region_reg));
    exec_add_next   = sat_add(exec_reg, exec_amt);
    scan_pc         = popcount(table_reg[scan_idx_reg[IW-1:0]]);
    scan_sum_next   = sum_reg + scan_pc;
    scan_max_next   = (scan_pc > max_reg) ? scan_pc : max_reg;
    scan_last       = (scan_idx_reg == last_idx);
    structured_next = (count_reg >= 8'd2) &&
                      (scan_sum_next < 32'(AVG_THRESH) * {24'b0, count_reg}) &&
                      (scan_max_next < 32'(MAX_THRESH));
    cost_sum        = {1'b0, disc_reg} + {1'b0, exec_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      op_reg       <= '0;
      m1_reg       <= '0;
      m2_reg       <= '0;
      region_reg   <= '0;
      for (int k = 0; k < MAX_MODULES; k++) table_reg[k] <= '0;
      count_reg    <= '0;
      result_reg   <= '0;
      scan_idx_reg <= '0;
      struct_reg   <= 1'b0;
      sat_reg      <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      code_reg     <= '0;
      disc_reg     <= '0;
      exec_reg     <= '0;
      sum_reg      <= '0;
      max_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (op_valid) begin
            op_reg     <= op;
            region_reg <= arg_region;
            m1_reg     <= arg_m1;
            m2_reg     <= arg_m2;
            state_reg  <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_reg <= S_DONE;
          done_reg  <= 1'b1;
          err_reg   <= 1'b0;
          code_reg  <= 3'd0;
          case (op_reg)
            OP_PNEW: begin
              if (hit_any) begin
                result_reg <= hit_idx;
              end else if (table_full) begin
                err_reg  <= 1'b1;
                code_reg <= 3'd1;
              end else begin
                table_reg[count_reg[IW-1:0]] <= region_reg;
                result_reg <= count_reg;
                count_reg  <= count_reg + 8'd1;
                disc_reg   <= disc_add_next[MU_WIDTH-1:0];
                sat_reg    <= sat_reg | disc_add_next[MU_WIDTH];
              end
            end
            OP_PSPLIT: begin
              if (!m1_ok) begin
                err_reg  <= 1'b1;
                code_reg <= 3'd2;
              end else if (table_full) begin
                err_reg  <= 1'b1;
                code_reg <= 3'd1;
              end else begin
                table_reg[count_reg[IW-1:0]] <= table_reg[m1_reg[IW-1:0]] & region_reg;
                table_reg[m1_reg[IW-1:0]]    <= table_reg[m1_reg[IW-1:0]] & ~region_reg;
                result_reg <= count_reg;
                count_reg  <= count_reg + 8'd1;
                exec_reg   <= exec_add_next[MU_WIDTH-1:0];
                sat_reg    <= sat_reg | exec_add_next[MU_WIDTH];
              end
            end
            OP_PMERGE: begin
              if (!m1_ok || !m2_ok) begin
                err_reg  <= 1'b1;
                code_reg <= 3'd2;
              end else if (m1_reg == m2_reg) begin
                err_reg  <= 1'b1;
                code_reg <= 3'd3;
              end else begin
                table_reg[m1_reg[IW-1:0]] <= merge_val;
                if (m2_reg != last_idx) table_reg[m2_reg[IW-1:0]] <= tail_val;
                table_reg[last_idx[IW-1:0]] <= '0;
                result_reg <= m1_reg;
                count_reg  <= last_idx;
                exec_reg   <= exec_add_next[MU_WIDTH-1:0];
                sat_reg    <= sat_reg | exec_add_next[MU_WIDTH];
              end
            end
            OP_MDLACC: begin
              result_reg <= count_reg;
              if (count_reg >= 8'd2) begin
                state_reg    <= S_SCAN;
                done_reg     <= 1'b0;
                scan_idx_reg <= '0;
                sum_reg      <= '0;
                max_reg      <= '0;
              end else begin
                struct_reg <= 1'b0;
                exec_reg   <= exec_add_next[MU_WIDTH-1:0];
                sat_reg    <= sat_reg | exec_add_next[MU_WIDTH];
              end
            end
            default: begin
              err_reg  <= 1'b1;
              code_reg <= 3'd4;
            end
          endcase
        end
        S_SCAN: begin
          if (scan_last) begin
            struct_reg <= structured_next;
            exec_reg   <= exec_add_next[MU_WIDTH-1:0];
            sat_reg    <= sat_reg | exec_add_next[MU_WIDTH];
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            scan_idx_reg <= scan_idx_reg + 8'd1;
            sum_reg      <= scan_sum_next;
            max_reg      <= scan_max_next;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign op_ready      = (state_reg == S_IDLE);
  assign done          = done_reg;
  assign err           = err_reg;
  assign err_code      = code_reg;
  assign result_id     = result_reg;
  assign num_modules   = count_reg;
  assign is_structured = struct_reg;
  assign mu_discovery  = disc_reg;
  assign mu_execution  = exec_reg;
  assign mu_sat        = sat_reg;
  assign mu_cost       = cost_sum[MU_WIDTH] ? {MU_WIDTH{1'b1}} : cost_sum[MU_WIDTH-1:0];
endmodule

// File: tb/tb_partition_engine.sv
// Randomized bench for partition_engine: a list-level table model predicts every
// completion, and directed sequences pin the model with hand-computed values.
module tb_partition_engine;
  localparam int MAXM   = 16;
  localparam int RW     = 128;
  localparam int MUW    = 12;
  localparam longint MU_MAX = (64'd1 << MUW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 op_valid = 1'b0;
  logic                 op_ready;
  logic [7:0]           op = '0;
  logic [RW-1:0]        arg_region = '0;
  logic [7:0]           arg_m1 = '0, arg_m2 = '0;
  logic                 done, err, is_structured, mu_sat;
  logic [2:0]           err_code;
  logic [7:0]           result_id, num_modules;
  logic [MUW-1:0]       mu_discovery, mu_execution, mu_cost;
  logic [MAXM*RW-1:0]   partitions;

  partition_engine #(.MAX_MODULES(MAXM), .REGION_WIDTH(RW), .MU_WIDTH(MUW),
                     .AVG_THRESH(8), .MAX_THRESH(16), .MERGE_COST(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .arg_region(arg_region), .arg_m1(arg_m1), .arg_m2(arg_m2), .done(done), .err(err),
    .err_code(err_code), .result_id(result_id), .num_modules(num_modules),
    .is_structured(is_structured), .mu_discovery(mu_discovery), .mu_execution(mu_execution),
    .mu_cost(mu_cost), .mu_sat(mu_sat), .partitions(partitions));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: a plain list of regions plus ledgers.
  logic [RW-1:0] m_tab [MAXM];
  int            m_cnt;
  longint        m_disc, m_exec;
  bit            m_sat, m_struct;
  bit            e_err;
  int            e_code, e_res, e_lat, last_lat;
  bit            pending = 1'b0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint mu_add(input longint a, input longint b);
    if (a + b > MU_MAX) begin
      m_sat = 1'b1;
      return MU_MAX;
    end
    return a + b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < MAXM; k++) m_tab[k] = '0;
    m_cnt = 0; m_disc = 0; m_exec = 0; m_sat = 0; m_struct = 0;
  endtask

  task automatic model_apply(input logic [7:0] o, input logic [RW-1:0] r,
                             input logic [7:0] a1, input logic [7:0] a2);
    int hit, last;
    longint s, mx;
    e_err = 0; e_code = 0; e_lat = 2;
    case (o)
      8'h00: begin
        hit = -1;
        for (int k = 0; k < m_cnt; k++) if (hit < 0 && m_tab[k] == r) hit = k;
        if (hit >= 0) e_res = hit;
        else if (m_cnt == MAXM) begin e_err = 1; e_code = 1; end
        else begin
          m_tab[m_cnt] = r; e_res = m_cnt; m_cnt++;
          m_disc = mu_add(m_disc, $countones(r));
        end
      end
      8'h01: begin
        if (int'(a1) >= m_cnt) begin e_err = 1; e_code = 2; end
        else if (m_cnt == MAXM) begin e_err = 1; e_code = 1; end
        else begin
          m_tab[m_cnt] = m_tab[a1] & r;
          m_tab[a1]    = m_tab[a1] & ~r;
          e_res = m_cnt; m_cnt++;
          m_exec = mu_add(m_exec, RW);
        end
      end
      8'h02: begin
        if (int'(a1) >= m_cnt || int'(a2) >= m_cnt) begin e_err = 1; e_code = 2; end
        else if (a1 == a2) begin e_err = 1; e_code = 3; end
        else begin
          m_tab[a1] = m_tab[a1] | m_tab[a2];
          last = m_cnt - 1;
          if (int'(a2) != last) m_tab[a2] = m_tab[last];
          m_tab[last] = '0;
          m_cnt--; e_res = a1;
          m_exec = mu_add(m_exec, 4);
        end
      end
      8'h05: begin
        s = 0; mx = 0;
        for (int k = 0; k < m_cnt; k++) begin
          s += $countones(m_tab[k]);
          if ($countones(m_tab[k]) > mx) mx = $countones(m_tab[k]);
        end
        m_struct = (m_cnt >= 2) && (s < 8 * m_cnt) && (mx < 16);
        e_res = m_cnt;
        m_exec = mu_add(m_exec, 8 * m_cnt);
        if (m_cnt >= 2) e_lat = 2 + m_cnt;
      end
      default: begin e_err = 1; e_code = 4; end
    endcase
  endtask

  function automatic longint model_cost();
    return (m_disc + m_exec > MU_MAX) ? MU_MAX : m_disc + m_exec;
  endfunction

  // Compare process: full check at every completion, state check while idle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (!pending) chk("spurious_done", done, 0);
        else begin
          chk("err", err, e_err);
          if (e_err) chk("err_code", err_code, e_code);
          else chk("result_id", result_id, e_res);
          chk("is_structured", is_structured, m_struct);
          chk("num_modules", num_modules, m_cnt);
          chk("mu_discovery", mu_discovery, m_disc);
          chk("mu_execution", mu_execution, m_exec);
          chk("mu_cost", mu_cost, model_cost());
          chk("mu_sat", mu_sat, m_sat);
          for (int k = 0; k < MAXM; k++) chk($sformatf("slot%0d", k), partitions[k*RW +: RW], m_tab[k]);
          pending = 1'b0;
        end
      end else if (op_ready && !pending) begin
        chk("idle_num_modules", num_modules, m_cnt);
        chk("idle_mu_cost", mu_cost, model_cost());
      end
    end
  end

  task automatic do_op(input logic [7:0] o, input logic [RW-1:0] r,
                       input logic [7:0] a1, input logic [7:0] a2);
    int n, lat;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 100) begin @(negedge clk); n++; end
    if (!op_ready) begin chk("op_ready_timeout", op_ready, 1); return; end
    op = o; arg_region = r; arg_m1 = a1; arg_m2 = a2; op_valid = 1'b1;
    @(posedge clk);
    model_apply(o, r, a1, a2);
    pending = 1'b1;
    #1;
    op_valid = 1'b0;
    op = 8'($urandom); arg_region = {$urandom, $urandom, $urandom, $urandom};
    arg_m1 = 8'($urandom); arg_m2 = 8'($urandom);
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!done) begin chk("done_timeout", done, 1); pending = 1'b0; end
    else chk("latency", lat, e_lat);
    last_lat = lat;
    $display("[TB] op=%02h m1=%0d m2=%0d -> err=%0b code=%0d res=%0d n=%0d lat=%0d",
             o, a1, a2, err, err_code, result_id, num_modules, lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    pending = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [RW-1:0] rand_region();
    logic [RW-1:0] r;
    int nb;
    r = '0;
    nb = $urandom_range(0, 20);
    for (int i = 0; i < nb; i++) r[$urandom_range(0, RW-1)] = 1'b1;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] pool [8];
    logic [7:0] o;
    int p;
    model_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_done", done, 0);
    chk("rst_num_modules", num_modules, 0);
    chk("rst_mu_discovery", mu_discovery, 0);
    chk("rst_slot0", partitions[RW-1:0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_op_ready", op_ready, 1);

    do_op(8'h00, 128'h0F, 0, 0);  chk("pnew_a_id", result_id, 0); chk("pnew_a_lat", last_lat, 2);
    do_op(8'h00, 128'hF0, 0, 0);  chk("pnew_b_id", result_id, 1); chk("pnew_b_lat", last_lat, 2);
    do_op(8'h00, 128'h0F, 0, 0);  chk("pnew_dup_id", result_id, 0); chk("pnew_dup_lat", last_lat, 2);
    chk("pnew_count", num_modules, 2);
    chk("pnew_disc", mu_discovery, 8);

    do_op(8'h01, 128'h03, 0, 0);
    chk("split_slot0", partitions[0 +: RW], 128'h0C);
    chk("split_slot2", partitions[2*RW +: RW], 128'h03);
    chk("split_id", result_id, 2);
    chk("split_exec", mu_execution, 128);

    do_reset();
    do_op(8'h00, 128'h0F, 0, 0);
    do_op(8'h00, 128'hF0, 0, 0);
    do_op(8'h00, 128'h33, 0, 0);
    do_op(8'h02, '0, 0, 1);
    chk("merge_slot0", partitions[0 +: RW], 128'hFF);
    chk("merge_slot1", partitions[RW +: RW], 128'h33);
    chk("merge_slot2", partitions[2*RW +: RW], 128'h0);
    chk("merge_count", num_modules, 2);
    chk("merge_exec", mu_execution, 4);
    do_op(8'h02, '0, 1, 1);
    chk("merge_same_err", err, 1);
    chk("merge_same_code", err_code, 3);
    chk("merge_same_count", num_modules, 2);
    chk("merge_same_exec", mu_execution, 4);

    do_reset();
    for (int i = 0; i < MAXM; i++) do_op(8'h00, 128'h1 << i, 0, 0);
    do_op(8'h00, 128'h1 << MAXM, 0, 0);
    chk("full_err", err, 1);
    chk("full_code", err_code, 1);
    chk("full_count", num_modules, MAXM);

    do_reset();
    for (int i = 0; i < 4; i++) do_op(8'h00, 128'h1 << (4 * i), 0, 0);
    do_op(8'h05, '0, 0, 0);
    chk("mdl_struct", is_structured, 1);
    chk("mdl_lat", last_lat, 6);
    chk("mdl_exec", mu_execution, 32);
    chk("mdl_result", result_id, 4);

    // Random phase against the model.
    do_reset();
    for (int i = 0; i < 8; i++) pool[i] = rand_region();
    for (int t = 0; t < 300; t++) begin
      p = $urandom_range(0, 99);
      if (p < 35) o = 8'h00;
      else if (p < 55) o = 8'h01;
      else if (p < 75) o = 8'h02;
      else if (p < 90) o = 8'h05;
      else begin
        o = 8'($urandom_range(0, 255));
        if (o == 8'h00 || o == 8'h01 || o == 8'h02 || o == 8'h05) o = 8'h33;
      end
      do_op(o, ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : rand_region(),
            8'($urandom_range(0, m_cnt + 1)), 8'($urandom_range(0, m_cnt + 1)));
    end

    // Drive the execution ledger to within one split of saturation.
    do_reset();
    do_op(8'h00, 128'h1, 0, 0);
    do_op(8'h00, 128'h2, 0, 0);
    while (m_exec <= MU_MAX - RW) do_op(8'h05, '0, 0, 0);
    chk("pre_sat_exec", mu_execution, 3968);
    chk("pre_sat_flag", mu_sat, 0);
    do_op(8'h01, 128'h1, 0, 0);
    chk("sat_exec", mu_execution, 4095);
    chk("sat_flag", mu_sat, 1);
    chk("sat_cost", mu_cost, 4095);
    do_op(8'h33, '0, 0, 0);
    chk("badop_err", err, 1);
    chk("badop_code", err_code, 4);

    // Reset in the middle of an MDLACC scan over three modules.
    @(negedge clk);
    while (!op_ready) @(negedge clk);
    op = 8'h05; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #2;
    chk("scan_busy", op_ready, 0);
    rst_n = 1'b0;
    model_reset();
    pending = 1'b0;
    #1;
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    chk("mid_code", err_code, 0);
    chk("mid_result", result_id, 0);
    chk("mid_count", num_modules, 0);
    chk("mid_struct", is_structured, 0);
    chk("mid_disc", mu_discovery, 0);
    chk("mid_exec", mu_execution, 0);
    chk("mid_cost", mu_cost, 0);
    chk("mid_sat", mu_sat, 0);
    for (int k = 0; k < MAXM; k++) chk($sformatf("mid_slot%0d", k), partitions[k*RW +: RW], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_op_ready", op_ready, 1);
    repeat (8) begin @(posedge clk); #1; chk("mid_no_done", done, 0); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/partition_engine.md
PARTITION_ENGINE -- requirements
Module: partition_engine

Interface
REQ-001 SHALL have parameter MAX_MODULES, default 16, meaning partition table depth (2..64).
REQ-002 SHALL have parameter REGION_WIDTH, default 128, meaning region mask bits per module.
REQ-003 SHALL have parameter MU_WIDTH, default 32, meaning width of each μ counter.
REQ-004 SHALL have parameter AVG_THRESH, default 8, meaning the structured average-size bound.
REQ-005 SHALL have parameter MAX_THRESH, default 16, meaning the structured max-size bound.
REQ-006 SHALL have parameter MERGE_COST, default 4, meaning the PMERGE μ charge.
REQ-007 SHALL have ports, in order:
- clk  in  1  clock; one clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op_valid  in  1  operation request.
- op_ready  out  1  high only in IDLE.
- op  in  8  opcode: 00 PNEW, 01 PSPLIT, 02 PMERGE, 05 MDLACC.
- arg_region  in  REGION_WIDTH  PNEW region / PSPLIT mask.
- arg_m1  in  8  PSPLIT module / PMERGE first module.
- arg_m2  in  8  PMERGE second module.
- done  out  1  one-cycle completion pulse.
- err  out  1  completion with error, valid with done.
- err_code  out  3  0 none, 1 full, 2 bad id, 3 same id, 4 bad opcode.
- result_id  out  8  result module index / module count.
- num_modules  out  8  active module count.
- is_structured  out  1  last classification.
- mu_discovery, mu_execution  out  MU_WIDTH each  μ ledgers.
- mu_cost  out  MU_WIDTH  saturating sum of the two ledgers.
- mu_sat  out  1  sticky, set when any μ add saturates.
- partitions  out  MAX_MODULES*REGION_WIDTH  flattened table, slot k at bits [k*REGION_WIDTH +: REGION_WIDTH].

Function
REQ-008 SHALL run FSM states IDLE, EXEC, SCAN, DONE.
- IDLE->EXEC on op_valid&op_ready.
- EXEC->SCAN for MDLACC with num_modules>=2.
- EXEC->DONE for all other cases.
- SCAN->DONE after the last active slot.
- DONE->IDLE unconditionally.
REQ-009 SHALL capture op and all args at the acceptance edge; later input changes have no effect on the operation in flight.
REQ-010 SHALL assert done exactly one cycle, in DONE; latency acceptance->done = 2 cycles, or 2+num_modules for scanned MDLACC.
REQ-011 PNEW with region equal to an active slot SHALL return that index, no table change, no μ charge.
REQ-012 PNEW otherwise SHALL write slot num_modules, return its index, increment the count, and add popcount(region) to mu_discovery; if the table is full: err, code 1.
REQ-013 PSPLIT SHALL set the new slot to old&mask and the old slot to old&~mask, return the new index, and add REGION_WIDTH to mu_execution.
- m1>=num_modules: code 2.
- table full: code 1.
REQ-014 PMERGE SHALL OR m2 into m1, move the last active slot into m2 (if m2 is not last), zero the old tail, decrement the count, return m1, and add MERGE_COST.
- m1 or m2 out of range: code 2.
- m1==m2: code 3.
REQ-015 MDLACC SCAN SHALL visit one slot per cycle, accumulating popcount sum S and max M.
REQ-016 MDLACC SHALL set is_structured=1 iff N>=2 and S<AVG_THRESH*N and M<MAX_THRESH (N=num_modules); otherwise 0.
REQ-017 MDLACC SHALL set result_id=N and add 8*N to mu_execution.
REQ-018 Any other opcode SHALL complete with err, code 4, and no state change.
REQ-019 Errored operations SHALL leave the table, count, and μ ledgers unchanged.
REQ-020 μ additions SHALL saturate at 2^MU_WIDTH-1 and set mu_sat.
REQ-021 mu_cost SHALL be computed combinationally from the two ledgers.

Reset
REQ-022 rst_n low SHALL asynchronously clear all of the following and enter IDLE, including mid-operation (operation discarded, no done):
- table, num_modules, result_id, is_structured
- both ledgers, mu_sat, done, err, err_code

Verification
REQ-023 Bench SHALL cover, after reset:
- PNEW 0x0F, PNEW 0xF0, PNEW 0x0F -> ids 0, 1, 0; num_modules=2; mu_discovery=8; done 2 cycles after each acceptance.
- PSPLIT m1=0 mask 0x03 on 0x0F -> slot0=0x0C, slot2=0x03, result_id=2, mu_execution=128.
- PMERGE 0,1 with three modules -> slot0=0xFF, slot1=old slot2, slot2=0, num_modules=2, mu_execution +4; PMERGE 1,1 -> err code 3, nothing changed.
- MAX_MODULES PNEWs then one more -> last one err code 1; MDLACC with 4 one-bit regions -> is_structured=1, done 6 cycles after acceptance, mu_execution +32.
- Ledger preloaded near 2^MU_WIDTH-1 then PSPLIT -> saturates, mu_sat=1; opcode 0x33 -> err code 4.
- rst_n pulsed during SCAN -> all outputs zero, no done pulse, op_ready=1 next cycle.
